// File: rtl/div_err_monitor.sv
// div_err_monitor: recomputes exact 16/8 division to score an approximate divider.
// Define DIV_ERR_REM_CHECK_EN to also score the remainder and expose port red.
module div_err_monitor #(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      x,
   input  logic [7:0]       y,
   input  logic [7:0]       q_apx,
   input  logic [7:0]       r_apx,
   output logic             res_valid,
   output logic [7:0]       q_exact,
   output logic [7:0]       r_exact,
   output logic [7:0]       ed,
`ifdef DIV_ERR_REM_CHECK_EN
   output logic [7:0]       red,
`endif
   output logic             err_flag,
   output logic             skip_flag,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [ACC_W-1:0] sum_ed,
   output logic [7:0]       max_ed
);

   localparam int unsigned SUM_W  = ACC_W + 8;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [7:0]          x_lo, y_r, q_apx_r, rem;
   logic [6:0]          q_acc;
   logic [STEP_W-1:0]   step;
   logic                accept_c, range_bad_c;
   logic [8:0]          t_c;
   logic                ge_c, err_c;
   logic [7:0]          rem_nxt_c, q_nxt_c, ed_c;
   logic [SUM_W-1:0]    sum_w_c;
`ifdef DIV_ERR_REM_CHECK_EN
   logic [7:0]          r_apx_r, red_c;
`endif

   assign accept_c    = (state == S_IDLE) && in_valid;
   assign range_bad_c = (y == 8'd0) || (x[15:8] >= y);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = range_bad_c ? S_DONE : S_CALC;
         S_CALC:  if (step == STEP_W'(0)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == S_IDLE);
         res_valid <= (state_nxt == S_DONE);
      end
   end

   // One restoring-division step plus the error terms of its result
   always_comb begin
      t_c       = {rem, x_lo[step]};
      ge_c      = (t_c >= {1'b0, y_r});
      rem_nxt_c = ge_c ? 8'(t_c - {1'b0, y_r}) : t_c[7:0];
      q_nxt_c   = {q_acc, ge_c};
      ed_c      = (q_nxt_c >= q_apx_r) ? (q_nxt_c - q_apx_r) : (q_apx_r - q_nxt_c);
      err_c     = (q_nxt_c != q_apx_r);
`ifdef DIV_ERR_REM_CHECK_EN
      red_c     = (rem_nxt_c >= r_apx_r) ? (rem_nxt_c - r_apx_r) : (r_apx_r - rem_nxt_c);
      err_c     = err_c | (rem_nxt_c != r_apx_r);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_lo      <= '0;
         y_r       <= '0;
         q_apx_r   <= '0;
         rem       <= '0;
         q_acc     <= '0;
         step      <= '0;
         q_exact   <= '0;
         r_exact   <= '0;
         ed        <= '0;
         err_flag  <= 1'b0;
         skip_flag <= 1'b0;
`ifdef DIV_ERR_REM_CHECK_EN
         r_apx_r   <= '0;
         red       <= '0;
`endif
      end else if (accept_c) begin
         x_lo    <= x[7:0];
         y_r     <= y;
         q_apx_r <= q_apx;
         rem     <= x[15:8];
         q_acc   <= '0;
         step    <= STEP_W'(7);
`ifdef DIV_ERR_REM_CHECK_EN
         r_apx_r <= r_apx;
`endif
         if (range_bad_c) begin
            q_exact   <= '0;
            r_exact   <= '0;
            ed        <= '0;
            err_flag  <= 1'b0;
            skip_flag <= 1'b1;
`ifdef DIV_ERR_REM_CHECK_EN
            red       <= '0;
`endif
         end
      end else if (state == S_CALC) begin
         rem   <= rem_nxt_c;
         q_acc <= q_nxt_c[6:0];
         step  <= step - STEP_W'(1);
         if (step == STEP_W'(0)) begin
            q_exact   <= q_nxt_c;
            r_exact   <= rem_nxt_c;
            ed        <= ed_c;
            err_flag  <= err_c;
            skip_flag <= 1'b0;
`ifdef DIV_ERR_REM_CHECK_EN
            red       <= red_c;
`endif
         end
      end
   end

   assign sum_w_c = SUM_W'(sum_ed) + SUM_W'(ed);

   // Saturating run statistics; clr has priority over a coincident update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         sum_ed     <= '0;
         max_ed     <= '0;
      end else if (clr) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         sum_ed     <= '0;
         max_ed     <= '0;
      end else if ((state == S_DONE) && !skip_flag) begin
         if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
         if (err_flag && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
         sum_ed <= (|sum_w_c[SUM_W-1:ACC_W]) ? '1 : sum_w_c[ACC_W-1:0];
         if (ed > max_ed) max_ed <= ed;
      end
   end

endmodule

// File: tb/tb_div_err_monitor.sv
// Randomized self-checking bench for div_err_monitor: default instance plus a narrow
// ACC_W=4/CNT_W=4 instance sharing the same stimulus to exercise saturation.
module tb_div_err_monitor;

   logic        clk = 1'b0;
   logic        rst_n, clr, in_valid;
   logic [15:0] x;
   logic [7:0]  y, q_apx, r_apx;

   logic        in_ready, res_valid, err_flag, skip_flag;
   logic [7:0]  q_exact, r_exact, ed, max_ed;
   logic [15:0] sample_cnt, err_cnt;
   logic [23:0] sum_ed;

   logic        in_ready_s, res_valid_s, err_flag_s, skip_flag_s;
   logic [7:0]  q_exact_s, r_exact_s, ed_s, max_ed_s;
   logic [3:0]  sample_cnt_s, err_cnt_s, sum_ed_s;
`ifdef DIV_ERR_REM_CHECK_EN
   logic [7:0]  red, red_s;
`endif

   int checks = 0;
   int failures = 0;

   // model state
   longint t_cnt, t_err, t_sum, t_max;
   int     e_q, e_r, e_ed, e_red, e_err, e_skip;
   int     o_q, o_r, o_ed, o_red, o_err, o_skip, lat;

   always #5 clk = ~clk;

   div_err_monitor u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .q_apx(q_apx), .r_apx(r_apx), .res_valid(res_valid),
      .q_exact(q_exact), .r_exact(r_exact), .ed(ed),
`ifdef DIV_ERR_REM_CHECK_EN
      .red(red),
`endif
      .err_flag(err_flag), .skip_flag(skip_flag), .sample_cnt(sample_cnt),
      .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed)
   );

   div_err_monitor #(.ACC_W(4), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
      .x(x), .y(y), .q_apx(q_apx), .r_apx(r_apx), .res_valid(res_valid_s),
      .q_exact(q_exact_s), .r_exact(r_exact_s), .ed(ed_s),
`ifdef DIV_ERR_REM_CHECK_EN
      .red(red_s),
`endif
      .err_flag(err_flag_s), .skip_flag(skip_flag_s), .sample_cnt(sample_cnt_s),
      .err_cnt(err_cnt_s), .sum_ed(sum_ed_s), .max_ed(max_ed_s)
   );

   function automatic int sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return int'((v > mx) ? mx : v);
   endfunction

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic model_zero();
      t_cnt = 0; t_err = 0; t_sum = 0; t_max = 0;
   endtask

   // Drive one sample, hold busy-time garbage on the inputs, capture the result.
   task automatic run_sample(input logic [15:0] sx, input logic [7:0] sy,
                             input logic [7:0] sqa, input logic [7:0] sra, input bit do_clr);
      int w;
      e_skip = ((sy == 8'd0) || (int'(sx[15:8]) >= int'(sy))) ? 1 : 0;
      if (e_skip != 0) begin
         e_q = 0; e_r = 0; e_ed = 0; e_red = 0; e_err = 0;
      end else begin
         e_q   = int'(sx) / int'(sy);
         e_r   = int'(sx) % int'(sy);
         e_ed  = absdiff(e_q, int'(sqa));
         e_red = absdiff(e_r, int'(sra));
         e_err = (e_q != int'(sqa)) ? 1 : 0;
`ifdef DIV_ERR_REM_CHECK_EN
         if (e_r != int'(sra)) e_err = 1;
`endif
      end
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
      x = sx; y = sy; q_apx = sqa; r_apx = sra; in_valid = 1'b1;
      @(posedge clk); #1;
      x = 16'($urandom); y = 8'($urandom); q_apx = 8'($urandom); r_apx = 8'($urandom);
      lat = 1;
      while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      in_valid = 1'b0;
      o_q = int'(q_exact); o_r = int'(r_exact); o_ed = int'(ed);
      o_err = int'(err_flag); o_skip = int'(skip_flag);
`ifdef DIV_ERR_REM_CHECK_EN
      o_red = int'(red);
`else
      o_red = e_red;
`endif
      if (do_clr) clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      if (do_clr) model_zero();
      else if (e_skip == 0) begin
         t_cnt++; t_err += e_err; t_sum += e_ed;
         if (e_ed > t_max) t_max = e_ed;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
      x = '0; y = '0; q_apx = '0; r_apx = '0;
      model_zero();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if ({q_exact, r_exact, ed, max_ed} !== 32'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", {q_exact, r_exact, ed, max_ed}); end
      checks++; if ({sample_cnt, err_cnt, sum_ed} !== 56'd0) begin failures++; $display("FAIL reset_stats: got %h expected 0", {sample_cnt, err_cnt, sum_ed}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_sample(16'd199, 8'd7, 8'd28, 8'd3, 1'b0);
      checks++; if (lat != 9) begin failures++; $display("FAIL d1_latency: got %0d expected 9", lat); end
      checks++; if (o_q != 28 || o_r != 3) begin failures++; $display("FAIL d1_qr: got %0d/%0d expected 28/3", o_q, o_r); end
      checks++; if (o_ed != 0 || o_err != 0) begin failures++; $display("FAIL d1_err: got ed=%0d err=%0d expected 0/0", o_ed, o_err); end
      checks++; if (int'(sample_cnt) != 1) begin failures++; $display("FAIL d1_sample_cnt: got %0d expected 1", sample_cnt); end
      run_sample(16'd127, 8'd5, 8'd24, 8'd7, 1'b0);
      checks++; if (o_q != 25 || o_r != 2) begin failures++; $display("FAIL d2_qr: got %0d/%0d expected 25/2", o_q, o_r); end
      checks++; if (o_ed != 1 || o_err != 1) begin failures++; $display("FAIL d2_err: got ed=%0d err=%0d expected 1/1", o_ed, o_err); end
      checks++; if (int'(err_cnt) != 1 || int'(sum_ed) != 1 || int'(max_ed) != 1) begin failures++; $display("FAIL d2_stats: got err_cnt=%0d sum=%0d max=%0d expected 1/1/1", err_cnt, sum_ed, max_ed); end
   endtask

   task automatic test_skip();
      run_sample(16'h0500, 8'd5, 8'd1, 8'd1, 1'b0);
      checks++; if (lat != 1 || o_skip != 1) begin failures++; $display("FAIL skip_range: got lat=%0d skip=%0d expected 1/1", lat, o_skip); end
      checks++; if (o_q != 0 || o_r != 0 || o_ed != 0 || o_err != 0) begin failures++; $display("FAIL skip_range_out: got %0d/%0d/%0d/%0d expected zeros", o_q, o_r, o_ed, o_err); end
      run_sample(16'd8, 8'd0, 8'd3, 8'd3, 1'b0);
      checks++; if (lat != 1 || o_skip != 1) begin failures++; $display("FAIL skip_div0: got lat=%0d skip=%0d expected 1/1", lat, o_skip); end
      checks++; if (int'(sample_cnt) != 2 || int'(sum_ed) != 1) begin failures++; $display("FAIL skip_stats: got cnt=%0d sum=%0d expected 2/1", sample_cnt, sum_ed); end
   endtask

   task automatic test_rem_check();
      int exp_err;
`ifdef DIV_ERR_REM_CHECK_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      run_sample(16'd40, 8'd13, 8'd3, 8'd0, 1'b0);
      checks++; if (o_ed != 0 || o_err != exp_err) begin failures++; $display("FAIL rem_check: got ed=%0d err=%0d expected 0/%0d", o_ed, o_err, exp_err); end
`ifdef DIV_ERR_REM_CHECK_EN
      checks++; if (o_red != 1) begin failures++; $display("FAIL rem_check_red: got %0d expected 1", o_red); end
`endif
   endtask

   task automatic test_reset_mid();
      int w;
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
      x = 16'd40; y = 8'd13; q_apx = 8'd0; r_apx = 8'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL midreset_hs: got ready=%b valid=%b expected 1/0", in_ready, res_valid); end
      checks++; if ({q_exact, r_exact, ed, err_flag, skip_flag} !== 26'd0) begin failures++; $display("FAIL midreset_out: got %h expected 0", {q_exact, r_exact, ed, err_flag, skip_flag}); end
      checks++; if ({sample_cnt, err_cnt, sum_ed, max_ed} !== 64'd0) begin failures++; $display("FAIL midreset_stats: got %h expected 0", {sample_cnt, err_cnt, sum_ed, max_ed}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_zero();
      @(posedge clk); #1;
      run_sample(16'd40, 8'd13, 8'd3, 8'd1, 1'b0);
      checks++; if (lat != 9 || o_q != 3 || o_r != 1) begin failures++; $display("FAIL midreset_resubmit: got lat=%0d q=%0d r=%0d expected 9/3/1", lat, o_q, o_r); end
   endtask

   task automatic test_saturation();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_zero();
      repeat (3) run_sample(16'd40, 8'd13, 8'd10, 8'd1, 1'b0);
      checks++; if (int'(sum_ed_s) != 15 || int'(sum_ed) != 21) begin failures++; $display("FAIL sat_sum: got narrow=%0d wide=%0d expected 15/21", sum_ed_s, sum_ed); end
      checks++; if (int'(max_ed) != 7 || int'(sample_cnt_s) != 3) begin failures++; $display("FAIL sat_max_cnt: got max=%0d cnt=%0d expected 7/3", max_ed, sample_cnt_s); end
      run_sample(16'd40, 8'd13, 8'd10, 8'd1, 1'b1);
      checks++; if ({sample_cnt, err_cnt, sum_ed, max_ed} !== 64'd0) begin failures++; $display("FAIL clr_on_done: got %h expected 0", {sample_cnt, err_cnt, sum_ed, max_ed}); end
      checks++; if ({sample_cnt_s, err_cnt_s, sum_ed_s, max_ed_s} !== 20'd0) begin failures++; $display("FAIL clr_on_done_narrow: got %h expected 0", {sample_cnt_s, err_cnt_s, sum_ed_s, max_ed_s}); end
   endtask

   task automatic test_random();
      logic [15:0] sx;
      logic [7:0]  sy, sqa, sra;
      int          qq, rr;
      bit          dc;
      for (int n = 0; n < 40; n++) begin
         sy = 8'($urandom_range(0, 255));
         if (sy == 8'd0 || $urandom_range(0, 9) == 0) sx = 16'($urandom);
         else sx = {8'($urandom_range(0, int'(sy) - 1)), 8'($urandom)};
         qq = (sy != 8'd0) ? int'(sx) / int'(sy) : 0;
         rr = (sy != 8'd0) ? int'(sx) % int'(sy) : 0;
         case ($urandom_range(0, 2))
            0:       begin sqa = 8'(qq); sra = 8'(rr); end
            1:       begin sqa = 8'(qq) ^ 8'(1 << $urandom_range(0, 7)); sra = 8'(rr); end
            default: begin sqa = 8'($urandom); sra = 8'($urandom); end
         endcase
         dc = ($urandom_range(0, 12) == 0);
         run_sample(sx, sy, sqa, sra, dc);
         checks++; if (lat != ((e_skip != 0) ? 1 : 9)) begin failures++; $display("FAIL rnd_latency: x=%0d y=%0d got %0d", sx, sy, lat); end
         checks++; if (o_skip != e_skip || o_q != e_q || o_r != e_r) begin failures++; $display("FAIL rnd_result: x=%0d y=%0d got skip=%0d q=%0d r=%0d expected %0d/%0d/%0d", sx, sy, o_skip, o_q, o_r, e_skip, e_q, e_r); end
         checks++; if (o_ed != e_ed || o_err != e_err || o_red != e_red) begin failures++; $display("FAIL rnd_error: x=%0d y=%0d got ed=%0d err=%0d red=%0d expected %0d/%0d/%0d", sx, sy, o_ed, o_err, o_red, e_ed, e_err, e_red); end
         checks++; if (int'(sample_cnt) != sat(t_cnt, 16) || int'(err_cnt) != sat(t_err, 16) || int'(sum_ed) != sat(t_sum, 24) || int'(max_ed) != int'(t_max)) begin failures++; $display("FAIL rnd_stats: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", sample_cnt, err_cnt, sum_ed, max_ed, sat(t_cnt, 16), sat(t_err, 16), sat(t_sum, 24), t_max); end
         checks++; if (int'(sample_cnt_s) != sat(t_cnt, 4) || int'(err_cnt_s) != sat(t_err, 4) || int'(sum_ed_s) != sat(t_sum, 4)) begin failures++; $display("FAIL rnd_stats_narrow: got %0d/%0d/%0d expected %0d/%0d/%0d", sample_cnt_s, err_cnt_s, sum_ed_s, sat(t_cnt, 4), sat(t_err, 4), sat(t_sum, 4)); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_skip();
      test_rem_check();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
